nibble_status_printer: RTL and testbench

//  Transmit side of the nibble data/enable status interface: captures one (data, en) sample
//  and serialises it as an ASCII text line "my_data=0x<hex> en=<bit>" + EOL on a byte stream.

---
 rtl/nibble_status_printer.sv | 232 +++++++++++++++++++++++
 tb/tb_nibble_status_printer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_status_printer.sv
// Serialises one captured (data, en) sample as the ASCII line "my_data=0x<hex> en=<bit>" + EOL.
// Optional feature: define STATUS_PRINTER_CRLF_EN to emit 8'h0D before EOL_CHAR.
module nibble_status_printer #(
  parameter int          DATA_W   = 4,
  parameter logic [7:0]  EOL_CHAR = 8'h0A
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_en,
  output logic              sample_ready,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready,
  output logic              busy,
  output logic [15:0]       line_cnt
);

  localparam int NIB = DATA_W / 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREFIX = 3'd1,
    ST_HEX    = 3'd2,
    ST_MID    = 3'd3,
    ST_EN     = 3'd4,
    ST_CR     = 3'd5,
    ST_EOL    = 3'd6
  } state_t;

  state_t              state_r, state_s;
  logic [3:0]          idx_r, idx_s;
  logic [DATA_W-1:0]   data_r;
  logic                en_r;
  logic                char_valid_r, char_valid_s;
  logic [7:0]          char_data_r, char_data_s;
  logic                busy_r;
  logic [15:0]         line_cnt_r;
  logic                xfer_s;
  logic                capture_s;
  logic                eol_xfer_s;

  function automatic logic [7:0] prefix_char(input logic [3:0] i);
    logic [7:0] c;
    case (i)
      4'd0:    c = 8'h6D; // m
      4'd1:    c = 8'h79; // y
      4'd2:    c = 8'h5F; // _
      4'd3:    c = 8'h64; // d
      4'd4:    c = 8'h61; // a
      4'd5:    c = 8'h74; // t
      4'd6:    c = 8'h61; // a
      4'd7:    c = 8'h3D; // =
      4'd8:    c = 8'h30; // 0
      4'd9:    c = 8'h78; // x
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] mid_char(input logic [3:0] i);
    logic [7:0] c;
    case (i)
      4'd0:    c = 8'h20;
      4'd1:    c = 8'h65;
      4'd2:    c = 8'h6E;
      4'd3:    c = 8'h3D;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) c = 8'h30 + {4'h0, n};
    else           c = 8'h57 + {4'h0, n};
    return c;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [DATA_W-1:0] d, input logic [3:0] i);
    logic [3:0] n;
    n = 4'h0;
    for (int k = 0; k < NIB; k++) begin
      if (i == 4'(k)) n = d[k*4 +: 4];
    end
    return n;
  endfunction

  // Index of the most significant non-zero nibble; 0 for an all-zero value so one digit prints.
  function automatic logic [3:0] top_digit(input logic [DATA_W-1:0] d);
    logic [3:0] t;
    t = 4'h0;
    for (int k = 0; k < NIB; k++) begin
      if (d[k*4 +: 4] != 4'h0) t = 4'(k);
    end
    return t;
  endfunction

  assign xfer_s       = char_valid_r && char_ready;
  assign capture_s    = sample_valid && (state_r == ST_IDLE);
  assign eol_xfer_s   = (state_r == ST_EOL) && xfer_s;
  assign sample_ready = (state_r == ST_IDLE);
  assign char_valid   = char_valid_r;
  assign char_data    = char_data_r;
  assign busy         = busy_r;
  assign line_cnt     = line_cnt_r;

  // State register: current FSM state and position within the current field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Next-state logic: fields advance only when the current byte is accepted.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_s) begin
          state_s = ST_PREFIX;
          idx_s   = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PREFIX: begin
        if (xfer_s) begin
          if (idx_r == 4'd9) begin
            state_s = ST_HEX;
            idx_s   = top_digit(data_r);
          end else begin
            idx_s = idx_r + 4'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      ST_HEX: begin
        if (xfer_s) begin
          if (idx_r == 4'd0) begin
            state_s = ST_MID;
            idx_s   = 4'd0;
          end else begin
            idx_s = idx_r - 4'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      ST_MID: begin
        if (xfer_s) begin
          if (idx_r == 4'd3) begin
            state_s = ST_EN;
            idx_s   = 4'd0;
          end else begin
            idx_s = idx_r + 4'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      ST_EN: begin
        if (xfer_s) begin
`ifdef STATUS_PRINTER_CRLF_EN
          state_s = ST_CR;
`else
          state_s = ST_EOL;
`endif
        end else begin
          state_s = ST_EN;
        end
      end
      ST_CR: begin
        if (xfer_s) state_s = ST_EOL;
        else        state_s = ST_CR;
      end
      ST_EOL: begin
        if (xfer_s) state_s = ST_IDLE;
        else        state_s = ST_EOL;
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = 4'd0;
      end
    endcase
  end

  // Output logic: byte for the state being entered, so the output register tracks the FSM.
  always_comb begin
    char_data_s  = 8'h00;
    char_valid_s = (state_s != ST_IDLE);
    case (state_s)
      ST_IDLE:   char_data_s = 8'h00;
      ST_PREFIX: char_data_s = prefix_char(idx_s);
      ST_HEX:    char_data_s = hex_char(nibble_at(data_r, idx_s));
      ST_MID:    char_data_s = mid_char(idx_s);
      ST_EN:     char_data_s = en_r ? 8'h31 : 8'h30;
      ST_CR:     char_data_s = 8'h0D;
      ST_EOL:    char_data_s = EOL_CHAR;
      default:   char_data_s = 8'h00;
    endcase
  end

  // Output, sample capture and line counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_valid_r <= 1'b0;
      char_data_r  <= 8'h00;
      busy_r       <= 1'b0;
      data_r       <= '0;
      en_r         <= 1'b0;
      line_cnt_r   <= 16'h0000;
    end else begin
      char_valid_r <= char_valid_s;
      char_data_r  <= char_data_s;
      busy_r       <= (state_s != ST_IDLE);
      if (capture_s) begin
        data_r <= sample_data;
        en_r   <= sample_en;
      end
      if (eol_xfer_s) line_cnt_r <= line_cnt_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_nibble_status_printer.sv
// Directed, table-driven bench for nibble_status_printer at DATA_W=4 and DATA_W=8.
module tb_nibble_status_printer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sv4, se4, sr4, cv4, cr4, busy4;
  logic [3:0] sd4;
  logic [7:0] cd4;
  logic [15:0] lc4;
  logic       sv8, se8, sr8, cv8, cr8, busy8;
  logic [7:0] sd8;
  logic [7:0] cd8;
  logic [15:0] lc8;

  nibble_status_printer #(.DATA_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sample_valid(sv4), .sample_data(sd4), .sample_en(se4),
    .sample_ready(sr4), .char_valid(cv4), .char_data(cd4), .char_ready(cr4),
    .busy(busy4), .line_cnt(lc4));

  nibble_status_printer #(.DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .sample_valid(sv8), .sample_data(sd8), .sample_en(se8),
    .sample_ready(sr8), .char_valid(cv8), .char_data(cd8), .char_ready(cr8),
    .busy(busy8), .line_cnt(lc8));

  int sel = 4;
  logic        obs_cv, obs_sr, obs_busy;
  logic [7:0]  obs_cd;
  logic [15:0] obs_lc;
  assign obs_cv   = (sel == 8) ? cv8   : cv4;
  assign obs_sr   = (sel == 8) ? sr8   : sr4;
  assign obs_busy = (sel == 8) ? busy8 : busy4;
  assign obs_cd   = (sel == 8) ? cd8   : cd4;
  assign obs_lc   = (sel == 8) ? lc8   : lc4;

  typedef struct {
    int         which;
    logic [7:0] data;
    logic       en;
    string      hex;
    bit         bp;
    bit         hold;
    logic [7:0] hold_data;
    logic       hold_en;
  } vec_t;

  vec_t        vecs[10];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt4 = 16'h0000;
  logic [15:0] exp_cnt8 = 16'h0000;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic r);
    if (sel == 8) begin
      sv8 = v; sd8 = d; se8 = e; cr8 = r;
    end else begin
      sv4 = v; sd4 = d[3:0]; se4 = e; cr4 = r;
    end
  endtask

  function automatic string exp_line(input string hex, input logic en);
    string s, e_s;
    e_s = en ? "1" : "0";
    s = {"my_data=0x", hex, " en=", e_s};
`ifdef STATUS_PRINTER_CRLF_EN
    s = {s, "\r"};
`endif
    s = {s, "\n"};
    return s;
  endfunction

  // Sends one sample and collects the line; called at a negedge with the DUT idle.
  task automatic run_line(input vec_t v);
    string      expl;
    logic [7:0] got_q[$];
    logic [7:0] held, dv;
    logic       vv, ev, rdy;
    bit         stalled;
    int         cyc, idx;
    expl = exp_line(v.hex, v.en);
    sel  = v.which;
    drive(1'b1, v.data, v.en, 1'b1);
    chk("ready_before_capture", obs_sr, 1);
    @(posedge clk);
    @(negedge clk);
    chk("first_byte_latency", obs_cv, 1);
    vv = v.hold; dv = v.hold ? v.hold_data : v.data; ev = v.hold ? v.hold_en : v.en;
    cyc = 0; stalled = 0; held = 8'h00;
    while (got_q.size() < expl.len() && cyc < 400) begin
      rdy = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.bp && !v.hold) begin
        vv = 1'($urandom_range(0, 1));
        dv = 8'($urandom);
        ev = 1'($urandom_range(0, 1));
      end
      drive(vv, dv, ev, rdy);
      if (stalled) chk("stall_hold", {obs_cv, obs_cd}, {1'b1, held});
      chk("valid_mid_line", obs_cv, 1);
      chk("ready_low_busy", {obs_sr, obs_busy}, 2'b01);
      if (obs_cv && rdy) got_q.push_back(obs_cd);
      stalled = obs_cv && !rdy;
      held    = obs_cd;
      cyc++;
      @(negedge clk);
    end
    chk("line_len", got_q.size(), expl.len());
    idx = expl.len() - 1;
    for (int i = expl.len() - 1; i >= 0; i--) begin
      if (i < got_q.size() && got_q[i] !== expl[i]) idx = i;
    end
    if (idx < got_q.size()) chk("line_byte", got_q[idx], expl[idx]);
    if (!v.bp) chk("line_cycles", cyc, expl.len());
    chk("idle_after_eol", {obs_cv, obs_sr, obs_busy}, 3'b010);
    if (v.which == 8) begin
      exp_cnt8 = exp_cnt8 + 16'd1;
      chk("line_cnt8", obs_lc, exp_cnt8);
    end else begin
      exp_cnt4 = exp_cnt4 + 16'd1;
      chk("line_cnt4", obs_lc, exp_cnt4);
    end
    if (!v.hold) drive(1'b0, dv, ev, 1'b1);
  endtask

  vec_t tmp;

  initial begin
    vecs[0] = '{4, 8'h0B, 1'b1, "b",  1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{4, 8'h00, 1'b0, "0",  1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{4, 8'h0A, 1'b0, "a",  1'b0, 1'b1, 8'h09, 1'b1};
    vecs[3] = '{4, 8'h09, 1'b1, "9",  1'b0, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{4, 8'h0B, 1'b1, "b",  1'b1, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8, 8'h05, 1'b0, "5",  1'b0, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{8, 8'h00, 1'b0, "0",  1'b0, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{8, 8'hA7, 1'b1, "a7", 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[8] = '{8, 8'h10, 1'b0, "10", 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[9] = '{8, 8'hFF, 1'b1, "ff", 1'b0, 1'b0, 8'h00, 1'b0};

    rst_n = 1'b0;
    sv4 = 1'b0; sd4 = 4'h0; se4 = 1'b0; cr4 = 1'b1;
    sv8 = 1'b0; sd8 = 8'h00; se8 = 1'b0; cr8 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dut4", {cv4, cd4, lc4, sr4, busy4}, {1'b0, 8'h00, 16'h0000, 1'b1, 1'b0});
    chk("reset_dut8", {cv8, cd8, lc8, sr8, busy8}, {1'b0, 8'h00, 16'h0000, 1'b1, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_line(vecs[i]);

    // Reset after seven bytes of a line: the partial line must never resume.
    sel = 4;
    drive(1'b1, 8'h07, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'h07, 1'b0, 1'b1);
    repeat (7) @(negedge clk);
    chk("pre_reset_busy", {obs_cv, obs_busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_line", {cv4, cd4, lc4, sr4, busy4}, {1'b0, 8'h00, 16'h0000, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt4 = 16'h0000;
    exp_cnt8 = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_bytes_after_reset", {cv4, busy4}, 2'b00);
    end
    tmp = '{4, 8'h03, 1'b1, "3", 1'b0, 1'b0, 8'h00, 1'b0};
    run_line(tmp);

    // Counter wrap: preload the count, then one line must bring it to zero.
    force dut4.line_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut4.line_cnt_r;
    @(negedge clk);
    exp_cnt4 = 16'hFFFF;
    tmp = '{4, 8'h0F, 1'b0, "f", 1'b0, 1'b0, 8'h00, 1'b0};
    run_line(tmp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
